// File: rtl/cnn_seq_pkg.sv
// Shared definitions for the CNN layer sequencer and its register map.
// State encoding, watchdog default and stage index sizing.
package cnn_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SCAN   = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_FINISH = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam int unsigned WDOG_W_DEF     = 24;
  localparam logic [23:0] WDOG_LIMIT_DEF = 24'hFFFFF;

  // idx must also reach NUM_STAGES to mark the end of the scan
  function automatic int stage_idx_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Saturating per-stage watchdog counter.
// tc flags the last allowed WAIT cycle.
module seq_watchdog #(
  parameter int unsigned  W     = 24,
  parameter logic [W-1:0] LIMIT = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  localparam logic [W-1:0] TC_VAL = LIMIT - W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && count != '1) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Runs the enabled CNN stages one at a time in index order,
// with a per-stage watchdog and cycle-count profiling.
module cnn_layer_sequencer
  import cnn_seq_pkg::*;
#(
  parameter int unsigned       NUM_STAGES = 4,
  parameter int unsigned       WDOG_W     = 24,
  parameter logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_LIMIT_DEF)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_STAGES-1:0] stage_en,
  output logic [NUM_STAGES-1:0] stage_start,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  error,
  output logic [2:0]            err_stage,
  input  logic [2:0]            cyc_sel,
  output logic [WDOG_W-1:0]     cyc_count
);

  localparam int unsigned IW = stage_idx_w(NUM_STAGES);

  state_t            state, state_n;
  logic [IW-1:0]     idx;
  logic [NUM_STAGES-1:0] en_q;
  logic [WDOG_W-1:0] cyc_q [NUM_STAGES];
  logic [WDOG_W-1:0] wdog;
  logic              wd_tc;
  logic              en_cur, done_cur, at_end;
  logic              go, inc, wr_cyc, tmo, abt;
  logic              wd_clr, wd_en;

  seq_watchdog #(
    .W     (WDOG_W),
    .LIMIT (WDOG_LIMIT)
  ) u_wdog (
    .clk   (clk),
    .reset (reset),
    .clr   (wd_clr),
    .en    (wd_en),
    .count (wdog),
    .tc    (wd_tc)
  );

  always_comb begin
    en_cur   = 1'b0;
    done_cur = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (idx == IW'(k)) begin
        en_cur   = en_q[k];
        done_cur = stage_done[k];
      end
    end
  end

  assign at_end = (idx == IW'(NUM_STAGES));

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    go      = 1'b0;
    inc     = 1'b0;
    wr_cyc  = 1'b0;
    tmo     = 1'b0;
    abt     = 1'b0;
    wd_clr  = 1'b0;
    wd_en   = 1'b0;
    unique case (state)
      S_IDLE, S_FAULT: begin
        if (start) begin
          go      = 1'b1;
          state_n = S_SCAN;
        end
      end
      S_SCAN: begin
        if (abort) begin
          abt     = 1'b1;
          state_n = S_IDLE;
        end else if (at_end) begin
          state_n = S_FINISH;
        end else if (en_cur) begin
          state_n = S_LAUNCH;
        end else begin
          inc = 1'b1;
        end
      end
      S_LAUNCH: begin
        wd_clr = 1'b1;
        if (abort) begin
          abt     = 1'b1;
          state_n = S_IDLE;
        end else begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        wd_en = 1'b1;
        if (abort) begin
          abt     = 1'b1;
          state_n = S_IDLE;
        end else if (done_cur) begin
          wr_cyc  = 1'b1;
          inc     = 1'b1;
          state_n = S_SCAN;
        end else if (wd_tc) begin
          tmo     = 1'b1;
          state_n = S_FAULT;
        end
      end
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= '0;
      en_q      <= '0;
      aborted   <= 1'b0;
      error     <= 1'b0;
      err_stage <= '0;
      for (int k = 0; k < NUM_STAGES; k++) cyc_q[k] <= '0;
    end else begin
      aborted <= abt;
      if (go) begin
        en_q  <= stage_en;
        idx   <= '0;
        error <= 1'b0;
      end else if (inc) begin
        idx <= idx + IW'(1);
      end
      if (tmo) begin
        error     <= 1'b1;
        err_stage <= 3'(idx);
      end
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (go) cyc_q[k] <= '0;
        else if (wr_cyc && idx == IW'(k)) cyc_q[k] <= wdog + WDOG_W'(1);
      end
    end
  end

  always_comb begin
    stage_start = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      stage_start[k] = (state == S_LAUNCH) && (idx == IW'(k));
    end
  end

  always_comb begin
    cyc_count = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (cyc_sel == 3'(k)) cyc_count = cyc_q[k];
    end
  end

  assign busy = (state == S_SCAN) || (state == S_LAUNCH) || (state == S_WAIT);
  assign done = (state == S_FINISH);

endmodule
